// File: rtl/genesys_pipe_pkg.sv
// Shared definitions for the pipeline-side blocks: counter width helper
// and error-flag bit positions.
package genesys_pipe_pkg;

    localparam int ERR_OVERFLOW_BIT = 0;
    localparam int ERR_CREDIT_BIT   = 1;
    localparam int ERR_W            = 2;

    typedef logic [ERR_W-1:0] err_vec_t;

    // Width able to hold every value 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipeline_credit_sink_if.sv
// Handshake bundle between the delay pipeline, its launcher, the credit
// sink and the downstream consumer.
interface pipeline_credit_sink_if
    import genesys_pipe_pkg::*;
#(
    parameter int NUM_BITS = 16,
    parameter int DEPTH    = 4
) ();
    localparam int CNT_W = cnt_width(DEPTH);

    logic                issue;
    logic                issue_ok;
    logic                in_valid;
    logic [NUM_BITS-1:0] in_data;
    logic                out_valid;
    logic [NUM_BITS-1:0] out_data;
    logic                out_ready;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    credits;
    logic                err_overflow;
    logic                err_credit;

    modport master (
        output issue, in_valid, in_data, out_ready,
        input  issue_ok, out_valid, out_data, count, credits, err_overflow, err_credit
    );

    modport slave (
        input  issue, in_valid, in_data, out_ready,
        output issue_ok, out_valid, out_data, count, credits, err_overflow, err_credit
    );
endinterface

// File: rtl/credit_ring_fifo.sv
// Circular FIFO with first-word fall-through read; callers guarantee no
// push while full without pop and no pop while empty.
module credit_ring_fifo
    import genesys_pipe_pkg::*;
#(
    parameter int  NUM_BITS = 16,
    parameter int  DEPTH    = 4,
    localparam int CNT_W    = cnt_width(DEPTH),
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [NUM_BITS-1:0] wr_data,
    output logic [NUM_BITS-1:0] rd_data,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                empty
);
    logic [NUM_BITS-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;

    assign full    = (count_r == CNT_W'(DEPTH));
    assign empty   = (count_r == {CNT_W{1'b0}});
    assign count   = count_r;
    // Stale storage is never exposed: the head reads as zero when empty.
    assign rd_data = empty ? {NUM_BITS{1'b0}} : mem_r[rd_ptr_r];

    // Storage array, deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/pipeline_credit_sink.sv
// Receiving end of a fixed-latency pipeline: buffers arriving items and
// returns credits to the launcher as the consumer drains them.
module pipeline_credit_sink
    import genesys_pipe_pkg::*;
#(
    parameter int  NUM_BITS = 16,
    parameter int  DEPTH    = 4,
    localparam int CNT_W    = cnt_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_credit_sink_if.slave  bus
);
    logic             push_s;
    logic             pop_s;
    logic             take_s;
    logic             full_s;
    logic             empty_s;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W-1:0] credits_r;
    logic [CNT_W-1:0] credits_nxt_s;
    err_vec_t         err_r;
    err_vec_t         err_nxt_s;

    credit_ring_fifo #(
        .NUM_BITS (NUM_BITS),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (bus.in_data),
        .rd_data (bus.out_data),
        .count   (count_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Handshake decode, credit arithmetic and sticky error accumulation.
    always_comb begin
        pop_s         = ~empty_s & bus.out_ready;
        push_s        = bus.in_valid & (~full_s | pop_s);
        take_s        = bus.issue & (credits_r != {CNT_W{1'b0}});
        credits_nxt_s = credits_r;
        err_nxt_s     = err_r;
        case ({take_s, pop_s})
            2'b10: credits_nxt_s = credits_r - CNT_W'(1);
            2'b01: begin
                if (credits_r != CNT_W'(DEPTH)) begin
                    credits_nxt_s = credits_r + CNT_W'(1);
                end else begin
                    credits_nxt_s = credits_r;
                end
            end
            default: credits_nxt_s = credits_r;
        endcase
        if (bus.in_valid & ~push_s) begin
            err_nxt_s[ERR_OVERFLOW_BIT] = 1'b1;
        end else begin
            err_nxt_s[ERR_OVERFLOW_BIT] = err_r[ERR_OVERFLOW_BIT];
        end
        if (bus.issue & (credits_r == {CNT_W{1'b0}})) begin
            err_nxt_s[ERR_CREDIT_BIT] = 1'b1;
        end else begin
            err_nxt_s[ERR_CREDIT_BIT] = err_r[ERR_CREDIT_BIT];
        end
    end

    // Credit and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_r <= CNT_W'(DEPTH);
            err_r     <= {ERR_W{1'b0}};
        end else begin
            credits_r <= credits_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    assign bus.issue_ok     = (credits_r != {CNT_W{1'b0}});
    assign bus.credits      = credits_r;
    assign bus.count        = count_s;
    assign bus.out_valid    = ~empty_s;
    assign bus.err_overflow = err_r[ERR_OVERFLOW_BIT];
    assign bus.err_credit   = err_r[ERR_CREDIT_BIT];
endmodule

// File: tb/tb_pipeline_credit_sink.sv
// Bench for pipeline_credit_sink: directed vector table, scenario sequences
// and randomized traffic through a 2-stage pipeline against a queue model.
module tb_pipeline_credit_sink;
    localparam int NB = 16;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_credit_sink_if #(.NUM_BITS(NB), .DEPTH(D)) bus ();

    pipeline_credit_sink #(.NUM_BITS(NB), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          issue;
        logic          in_valid;
        logic [NB-1:0] in_data;
        logic          out_ready;
        int            e_count;
        int            e_credits;
        logic          e_valid;
        logic [NB-1:0] e_data;
        logic          e_ok;
        logic          e_eovf;
        logic          e_ecred;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue contents, credit pool, sticky flags.
    logic [NB-1:0] q[$];
    int            m_cred;
    logic          m_eovf;
    logic          m_ecred;

    // Upstream 2-stage delay line and item numbering.
    logic          p_v[2];
    logic [NB-1:0] p_d[2];
    logic [NB-1:0] next_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cred  = D;
        m_eovf  = 1'b0;
        m_ecred = 1'b0;
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        p_d[0] = '0;   p_d[1] = '0;
    endtask

    task automatic model_step();
        bit pop, push, take;
        pop  = (q.size() != 0) && bus.out_ready;
        push = bus.in_valid && ((q.size() < D) || pop);
        take = bus.issue && (m_cred > 0);
        if (bus.in_valid && !push) m_eovf = 1'b1;
        if (bus.issue && m_cred == 0) m_ecred = 1'b1;
        m_cred = m_cred - int'(take) + int'(pop);
        if (m_cred > D) m_cred = D;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(bus.in_data);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
        check({tag, ".out_data"}, 32'(bus.out_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        check({tag, ".count"}, 32'(bus.count), 32'(q.size()));
        check({tag, ".credits"}, 32'(bus.credits), 32'(m_cred));
        check({tag, ".issue_ok"}, 32'(bus.issue_ok), 32'(m_cred != 0));
        check({tag, ".err_overflow"}, 32'(bus.err_overflow), 32'(m_eovf));
        check({tag, ".err_credit"}, 32'(bus.err_credit), 32'(m_ecred));
    endtask

    // One clock: advance the model and the delay line, return at the falling edge.
    task automatic tick();
        logic          iss;
        logic [NB-1:0] id;
        model_step();
        iss = bus.issue;
        id  = next_id;
        if (iss) next_id = next_id + 16'd1;
        @(posedge clk);
        p_v[1] = p_v[0]; p_d[1] = p_d[0];
        p_v[0] = iss;    p_d[0] = id;
        @(negedge clk);
    endtask

    task automatic drive_pipe();
        bus.in_valid = p_v[1];
        bus.in_data  = p_d[1];
    endtask

    task automatic idle_inputs();
        bus.issue = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    vec_t tbl[12];
    logic [NB-1:0] got[$];
    int sent, accepted;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 0, 3, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 16'hA001, 1'b0, 1, 2, 1'b1, 16'hA001, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 16'hA002, 1'b0, 2, 1, 1'b1, 16'hA001, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 16'hA003, 1'b0, 3, 0, 1'b1, 16'hA001, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 16'hA004, 1'b0, 4, 0, 1'b1, 16'hA001, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 16'hA005, 1'b1, 4, 1, 1'b1, 16'hA002, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 16'hA006, 1'b0, 4, 1, 1'b1, 16'hA002, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 3, 2, 1'b1, 16'hA003, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 2, 3, 1'b1, 16'hA004, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1, 4, 1'b1, 16'hA005, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 16'hA007, 1'b1, 1, 4, 1'b1, 16'hA007, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 0, 4, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        next_id = 16'd1;
        do_reset();

        // Reset then idle.
        check("rst.credits", 32'(bus.credits), 32'd4);
        check("rst.issue_ok", 32'(bus.issue_ok), 32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.count", 32'(bus.count), 32'd0);
        check("rst.out_data", 32'(bus.out_data), 32'd0);

        // Directed vectors: fill, credit error, full push+pop, overflow, drain.
        for (int i = 0; i < 12; i++) begin
            bus.issue     = tbl[i].issue;
            bus.in_valid  = tbl[i].in_valid;
            bus.in_data   = tbl[i].in_data;
            bus.out_ready = tbl[i].out_ready;
            tick();
            check($sformatf("vec%0d.count", i), 32'(bus.count), 32'(tbl[i].e_count));
            check($sformatf("vec%0d.credits", i), 32'(bus.credits), 32'(tbl[i].e_credits));
            check($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_valid));
            check($sformatf("vec%0d.out_data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
            check($sformatf("vec%0d.issue_ok", i), 32'(bus.issue_ok), 32'(tbl[i].e_ok));
            check($sformatf("vec%0d.err_overflow", i), 32'(bus.err_overflow), 32'(tbl[i].e_eovf));
            check($sformatf("vec%0d.err_credit", i), 32'(bus.err_credit), 32'(tbl[i].e_ecred));
        end
        idle_inputs();
        tick();
        tick();
        check("sticky.err_overflow", 32'(bus.err_overflow), 32'd1);
        check("sticky.err_credit", 32'(bus.err_credit), 32'd1);
        do_reset();
        check("clear.err_overflow", 32'(bus.err_overflow), 32'd0);
        check("clear.err_credit", 32'(bus.err_credit), 32'd0);

        // Streaming 8 items through the 2-stage pipeline, consumer always ready.
        next_id = 16'd1;
        sent = 0;
        for (int c = 0; c < 16; c++) begin
            bus.issue     = (sent < 8);
            bus.out_ready = 1'b1;
            drive_pipe();
            if (sent < 8) check("stream.issue_ok", 32'(bus.issue_ok), 32'd1);
            if (bus.issue) sent++;
            if (bus.out_valid) got.push_back(bus.out_data);
            check_model("stream");
            tick();
        end
        check("stream.n_items", 32'(got.size()), 32'd8);
        for (int k = 0; k < got.size() && k < 8; k++)
            check($sformatf("stream.item%0d", k), 32'(got[k]), 32'(k + 1));
        check("stream.err_overflow", 32'(bus.err_overflow), 32'd0);
        check("stream.err_credit", 32'(bus.err_credit), 32'd0);

        // Backpressure: issue whenever allowed with the consumer stalled.
        do_reset();
        next_id = 16'h0100;
        accepted = 0;
        for (int c = 0; c < 10; c++) begin
            bus.issue     = bus.issue_ok;
            bus.out_ready = 1'b0;
            drive_pipe();
            if (bus.issue) accepted++;
            tick();
        end
        check("bp.accepted", 32'(accepted), 32'd4);
        check("bp.issue_ok", 32'(bus.issue_ok), 32'd0);
        check("bp.count", 32'(bus.count), 32'd4);
        check("bp.head", 32'(bus.out_data), 32'h0100);
        bus.issue = 1'b0;
        bus.out_ready = 1'b1;
        drive_pipe();
        tick();
        bus.out_ready = 1'b0;
        check("bp.release.issue_ok", 32'(bus.issue_ok), 32'd1);
        check("bp.release.credits", 32'(bus.credits), 32'd1);
        check("bp.release.count", 32'(bus.count), 32'd3);
        check("bp.release.head", 32'(bus.out_data), 32'h0101);

        // Asynchronous reset mid-stream with three items stored.
        #2;
        rst = 1'b1;
        #1;
        check("arst.out_valid", 32'(bus.out_valid), 32'd0);
        check("arst.count", 32'(bus.count), 32'd0);
        check("arst.credits", 32'(bus.credits), 32'd4);
        check("arst.issue_ok", 32'(bus.issue_ok), 32'd1);
        check("arst.out_data", 32'(bus.out_data), 32'd0);
        do_reset();

        // Randomized traffic, including occasional illegal issues.
        next_id = 16'h1000;
        for (int c = 0; c < 400; c++) begin
            if (bus.issue_ok) bus.issue = 1'($urandom_range(0, 1));
            else              bus.issue = ($urandom_range(0, 15) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            drive_pipe();
            check_model("rand");
            tick();
        end
        check_model("rand.final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_credit_sink.md
# pipeline_credit_sink

Receiving end of a fixed-latency, non-stallable delay pipeline. It captures every item that leaves the pipeline in a small circular FIFO and presents it downstream with valid/ready backpressure. It also runs a credit counter that tells the upstream launcher when it may inject a new item, so no in-flight item can be lost. It sits between a delay-line pipeline and any consumer that can stall, such as the writeback or OBUF logic.

## Interface
- NUM_BITS, 16, data width.
- DEPTH, 4, FIFO entries and total credits; power of two, ≥ 2; must be ≥ pipeline latency + 1 for full throughput.
- CNT_W, $clog2(DEPTH+1), derived width of counters; not overridden.

- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- issue  input  1  upstream launched one item into the pipeline this cycle.
- issue_ok  output  1  a credit is available; upstream may assert issue this cycle.
- in_valid  input  1  pipeline output carries an item this cycle.
- in_data  input  NUM_BITS  pipeline output data.
- out_valid  output  1  FIFO head valid.
- out_data  output  NUM_BITS  FIFO head data.
- out_ready  input  1  consumer accepts head this cycle.
- count  output  CNT_W  items currently stored.
- credits  output  CNT_W  free credits.
- err_overflow  output  1  sticky: push while full and not popping.
- err_credit  output  1  sticky: issue while credits == 0.

## Operation
- Reset values:
  - credits = DEPTH; count = 0.
  - rd/wr pointers = 0; out_valid = 0; out_data = 0.
  - both error flags = 0; issue_ok = 1.
- push = in_valid && (count < DEPTH || pop).
- pop = out_valid && out_ready.
- Push writes in_data to mem[wr_ptr], and wr_ptr increments modulo DEPTH (natural wrap; DEPTH is a power of two).
- Pop increments rd_ptr modulo DEPTH.
- count next = count + push − pop.
- Credit counter:
  - decrements on (issue && credits != 0); increments on pop; both in the same cycle leaves it unchanged.
  - never exceeds DEPTH and never underflows.
- issue_ok = (credits != 0), combinational from the register.
- An issue while credits == 0 is ignored by the counter and sets err_credit.
- An in_valid while count == DEPTH and no pop drops the item, leaves state unchanged, and sets err_overflow.
- The error flags clear only on rst.
- out_valid = (count != 0). out_data = mem[rd_ptr], read combinationally (first-word fall-through).
- Storage is not reset; out_data is forced to 0 when count == 0.
- Asserting rst mid-operation discards all stored and in-flight items and restores the reset values immediately (asynchronously).

## Timing
- in_valid at edge t produces out_valid high after edge t, so the item is visible in cycle t+1 (1-cycle latency).
- A pop at edge t frees a credit: issue_ok rises in cycle t+1 if credits was 0.
- Credits are never returned combinationally.
- Simultaneous push and pop when full: both take effect, count stays at DEPTH, and no error is raised.
- Simultaneous push and pop when count == 1: out_data moves to the new item next cycle and out_valid stays high.
- Sustained throughput is 1 item/cycle when DEPTH ≥ L + 1 and the consumer is always ready, where L is the pipeline latency.

## Structure
- Shared package genesys_pipe_pkg holds the credit/count width function (clog2 of DEPTH+1) and the error-flag bit positions. The same package is reused by future pipeline-side blocks.
- One sub-module, credit_ring_fifo, holds the storage, pointers and count and exposes push/pop/full/empty.
- The top level adds the credit counter, issue_ok and the error flags.

## Test plan
- Reset then idle:
  - after rst deasserts: credits=4, issue_ok=1, out_valid=0, count=0, out_data=0.
- Streaming:
  - setup: DEPTH=4 with a 2-stage pipeline model, issue every cycle for 8 items (0x0001..0x0008), out_ready=1.
  - required: outputs 0x0001..0x0008 in order, one per cycle; issue_ok never drops; no errors.
- Backpressure:
  - setup: out_ready=0, issue whenever issue_ok.
  - required: exactly 4 issues accepted, then issue_ok=0 and count reaches 4.
  - release out_ready for 1 cycle: 1 pop, issue_ok=1 the next cycle, credits=1.
- Full simultaneous:
  - stimulus: count=4 while in_valid=1 and out_ready=1 in the same cycle.
  - required: count stays 4, head advances, err_overflow=0.
- Errors:
  - stimulus: force issue with credits=0, then in_valid while full with out_ready=0.
  - required: err_credit=1, then err_overflow=1, credits unchanged at 0, count stays 4; both flags clear only after rst.
- Reset mid-stream:
  - stimulus: assert rst asynchronously with count=3.
  - required: out_valid=0, count=0 and credits=4 immediately, before the next clk edge.
